led_disp_ctrl: RTL and testbench

Display stage directly downstream of the 0–59 seconds counter: takes its 6-bit count output and drives a 6-digit multiplexed 7-segment LED display. Binary count is converted to two BCD digits (ones on digit 0, tens on digit 1). Digits 2–5 are scanned but blank. The count is sampled once per scan frame so a frame never shows mixed values.

---
 rtl/led_disp_ctrl.sv | 116 +++++++++++
 tb/tb_led_disp_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/led_disp_ctrl.sv
// Six-digit multiplexed 7-segment driver for a 0-59 seconds count.
// Shows the BCD ones/tens on digits 0/1 and scans digits 2-5 blank.
module led_disp_ctrl #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          LZB      = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] cnt,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       frame
);

    localparam int unsigned PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(SCAN_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'd5;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    logic [PSC_W-1:0] psc;
    logic [2:0]       idx;
    logic [5:0]       val;

    logic       tick;
    logic       wrap;
    logic [2:0] idx_nxt;
    logic [5:0] dval;
    logic [5:0] tens_sub;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       invalid;
    logic [6:0] seg_nxt;
    logic [5:0] an_nxt;

    function automatic logic [6:0] digit_pat(input logic [3:0] d);
        case (d)
            4'd0:    digit_pat = 7'h3F;
            4'd1:    digit_pat = 7'h06;
            4'd2:    digit_pat = 7'h5B;
            4'd3:    digit_pat = 7'h4F;
            4'd4:    digit_pat = 7'h66;
            4'd5:    digit_pat = 7'h6D;
            4'd6:    digit_pat = 7'h7D;
            4'd7:    digit_pat = 7'h07;
            4'd8:    digit_pat = 7'h7F;
            4'd9:    digit_pat = 7'h6F;
            default: digit_pat = 7'h00;
        endcase
    endfunction

    // Next-slot decode; digit 0 bypasses the latch so it shows the value captured this edge.
    always_comb begin
        tick     = (psc == PSC_MAX);
        idx_nxt  = (idx >= IDX_LAST) ? 3'd0 : idx + 3'd1;
        wrap     = tick && (idx_nxt == 3'd0);
        dval     = wrap ? cnt : val;
        invalid  = (dval >= 6'd60);
        tens     = 4'd0;
        tens_sub = 6'd0;
        if (dval >= 6'd50) begin
            tens     = 4'd5;
            tens_sub = 6'd50;
        end else if (dval >= 6'd40) begin
            tens     = 4'd4;
            tens_sub = 6'd40;
        end else if (dval >= 6'd30) begin
            tens     = 4'd3;
            tens_sub = 6'd30;
        end else if (dval >= 6'd20) begin
            tens     = 4'd2;
            tens_sub = 6'd20;
        end else if (dval >= 6'd10) begin
            tens     = 4'd1;
            tens_sub = 6'd10;
        end
        ones    = 4'(dval - tens_sub);
        seg_nxt = SEG_BLANK;
        case (idx_nxt)
            3'd0: seg_nxt = invalid ? SEG_DASH : digit_pat(ones);
            3'd1: begin
                if (invalid)
                    seg_nxt = SEG_DASH;
                else if (LZB && (tens == 4'd0))
                    seg_nxt = SEG_BLANK;
                else
                    seg_nxt = digit_pat(tens);
            end
            default: seg_nxt = SEG_BLANK;
        endcase
        an_nxt = ~(6'(1) << idx_nxt);
    end

    // Prescaler, scan index, frame latch and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc   <= '0;
            idx   <= IDX_LAST;
            val   <= 6'd0;
            seg   <= SEG_BLANK;
            an    <= 6'b111111;
            frame <= 1'b0;
        end else begin
            psc   <= tick ? '0 : psc + PSC_W'(1);
            frame <= wrap;
            if (wrap)
                val <= cnt;
            if (tick) begin
                idx <= idx_nxt;
                seg <= seg_nxt;
                an  <= an_nxt;
            end
        end
    end

endmodule

// File: tb/tb_led_disp_ctrl.sv
// Bench for led_disp_ctrl: three builds (div 4, div 4 with LZB, div 1) against
// a reference model derived from edge counts and a history of sampled cnt values.
`timescale 1ns/1ps
module tb_led_disp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] cnt = 6'd37;

    logic [6:0] seg0, seg1, seg2;
    logic [5:0] an0, an1, an2;
    logic       frame0, frame1, frame2;

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic [5:0] hist [0:4095];

    led_disp_ctrl #(.SCAN_DIV(4), .LZB(1'b0)) u0 (
        .clk(clk), .rst(rst), .cnt(cnt), .seg(seg0), .an(an0), .frame(frame0));
    led_disp_ctrl #(.SCAN_DIV(4), .LZB(1'b1)) u1 (
        .clk(clk), .rst(rst), .cnt(cnt), .seg(seg1), .an(an1), .frame(frame1));
    led_disp_ctrl #(.SCAN_DIV(1), .LZB(1'b0)) u2 (
        .clk(clk), .rst(rst), .cnt(cnt), .seg(seg2), .an(an2), .frame(frame2));

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int d);
        logic [6:0] p [0:9];
        p = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return p[d];
    endfunction

    // Expected outputs after edge e since reset release for a build with divider d.
    task automatic model(input int d, input bit lzb, input int e,
                         output logic [6:0] s, output logic [5:0] a, output logic f);
        int slot, dig, fstart, v;
        s = 7'h00; a = 6'b111111; f = 1'b0;
        if (e >= d) begin
            slot   = e / d - 1;
            dig    = slot % 6;
            fstart = d * (1 + 6 * (slot / 6));
            v      = int'(hist[fstart]);
            f      = (e == fstart);
            a      = ~(6'(1) << dig);
            if (dig == 0)
                s = (v >= 60) ? 7'h40 : pat(v % 10);
            else if (dig == 1)
                s = (v >= 60) ? 7'h40 : ((lzb && v / 10 == 0) ? 7'h00 : pat(v / 10));
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp_v);
        end
    endtask

    task automatic check_all();
        logic [6:0] s; logic [5:0] a; logic f;
        model(4, 1'b0, n, s, a, f);
        chk("u0.seg", 8'(seg0), 8'(s)); chk("u0.an", 8'(an0), 8'(a)); chk("u0.frame", 8'(frame0), 8'(f));
        model(4, 1'b1, n, s, a, f);
        chk("u1.seg", 8'(seg1), 8'(s)); chk("u1.an", 8'(an1), 8'(a)); chk("u1.frame", 8'(frame1), 8'(f));
        model(1, 1'b0, n, s, a, f);
        chk("u2.seg", 8'(seg2), 8'(s)); chk("u2.an", 8'(an2), 8'(a)); chk("u2.frame", 8'(frame2), 8'(f));
    endtask

    task automatic step();
        @(posedge clk);
        if (n < 4095) n++;
        hist[n] = cnt;
        #1;
        check_all();
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        // Reset held across edges, then released with cnt=37.
        repeat (3) @(posedge clk);
        #1;
        n = 0;
        check_all();
        rst = 1'b0;
        run(30);

        // Latch 12 at a frame start, change to 45 one cycle later.
        for (int i = 0; i < 30 && ((n + 1 - 4) % 24) != 0; i++) step();
        cnt = 6'd12;
        step();
        cnt = 6'd45;
        run(48);

        // Wrap, zero, leading-zero and invalid values.
        cnt = 6'd59; run(48);
        cnt = 6'd0;  run(48);
        cnt = 6'd9;  run(48);
        cnt = 6'd62; run(48);

        // Asynchronous reset pulse while u0 drives digit 3.
        cnt = 6'd27;
        for (int i = 0; i < 30 && !(n >= 4 && ((n / 4) - 1) % 6 == 3); i++) step();
        rst = 1'b1;
        #1;
        checks++;
        assert (an0 === 6'b111111 && seg0 === 7'h00 && an2 === 6'b111111 && seg2 === 7'h00) else begin
            errors++;
            $error("FAIL async_rst observed an=%b seg=%h expected an=111111 seg=00", an0, seg0);
        end
        rst = 1'b0;
        n = 0;
        run(30);

        // Random count changes at random times.
        for (int i = 0; i < 40; i++) begin
            cnt = 6'($urandom_range(0, 63));
            run(int'($urandom_range(1, 30)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
